// File: rtl/hht_spmv_engine.sv
// Sparse row-gather multiply-accumulate engine.
// Streams packed (value, column) nonzeros from port 1 and gathers vector elements from
// port 2. It produces one dot product per row on a valid/ready output.
module hht_spmv_engine #(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned IDX_W   = 16,
   parameter int unsigned ACC_W   = 64,
   parameter int unsigned VEC_LEN = 16
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              start,
   input  logic              mode,
   input  logic [ADDR_W-1:0] v_values_base,
   input  logic [ADDR_W-1:0] wdata_col_base,
   input  logic [ADDR_W-1:0] csize,
   input  logic [ADDR_W-1:0] row_nnz,
   output logic [ADDR_W-1:0] addr1,
   output logic              rd1,
   input  logic [DATA_W-1:0] dataIn1,
   output logic [ADDR_W-1:0] addr2,
   output logic              rd2,
   input  logic [DATA_W-1:0] dataIn2,
   output logic [ACC_W-1:0]  y_data,
   output logic [ADDR_W-1:0] y_row,
   output logic              y_valid,
   input  logic              y_ready,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam int unsigned VAL_W = DATA_W - IDX_W;

   typedef enum logic [2:0] {StIdle, StRun, StDrain, StFin, StDone} state_e;

   state_e state_q, state_d;

   logic              mode_q;
   logic [ADDR_W-1:0] vbase_q, wbase_q, csize_q, rnnz_q;
   logic [ADDR_W-1:0] k_q, pos_q, row_q;
   logic              s1_valid_q, s1_first_q, s1_last_q;
   logic [IDX_W-1:0]  s1_col_q;
   logic [VAL_W-1:0]  s1_mval_q;
   logic [ACC_W-1:0]  acc_q, y_data_q;
   logic [ADDR_W-1:0] y_row_q;
   logic              y_valid_q, err_q, done_q;

   logic              cfg_ok, accept_start, reject_start;
   logic              stall, issue, last_issue, in_range, pos_last;
   logic [ACC_W-1:0]  product, sum;

   // Datapath decode: stall only when a finished row would overwrite an unaccepted result
   always_comb begin
      cfg_ok       = (csize != '0) && (row_nnz != '0) && ((csize % row_nnz) == '0);
      accept_start = (state_q == StIdle) && start && cfg_ok;
      reject_start = (state_q == StIdle) && start && !cfg_ok;
      stall        = y_valid_q && !y_ready && s1_valid_q && s1_last_q;
      issue        = (state_q == StRun) && !stall;
      last_issue   = issue && (k_q == csize_q - ADDR_W'(1));
      pos_last     = (pos_q == rnnz_q - ADDR_W'(1));
      in_range     = ADDR_W'(s1_col_q) < ADDR_W'(VEC_LEN);
      product      = in_range ? ACC_W'(s1_mval_q) * ACC_W'(dataIn2) : '0;
      sum          = (s1_first_q ? ACC_W'(0) : acc_q) + product;
      rd1          = (state_q == StRun);
      addr1        = rd1 ? wbase_q + k_q : '0;
      rd2          = s1_valid_q && in_range;
      addr2        = s1_valid_q ? vbase_q + ADDR_W'(s1_col_q) : '0;
      busy         = (state_q != StIdle);
      done         = (state_q == StDone) || done_q;
      y_data       = y_data_q;
      y_row        = y_row_q;
      y_valid      = y_valid_q;
      err          = err_q;
   end

   // Job sequencing
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (accept_start) state_d = StRun;
         StRun:   if (last_issue) state_d = StDrain;
         StDrain: if (!stall) state_d = StFin;
         StFin:   if (y_valid_q && y_ready) state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // State, config latch, two-stage pipeline and result register
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q    <= StIdle;
         mode_q     <= 1'b0;
         vbase_q    <= '0;
         wbase_q    <= '0;
         csize_q    <= '0;
         rnnz_q     <= '0;
         k_q        <= '0;
         pos_q      <= '0;
         row_q      <= '0;
         s1_valid_q <= 1'b0;
         s1_first_q <= 1'b0;
         s1_last_q  <= 1'b0;
         s1_col_q   <= '0;
         s1_mval_q  <= '0;
         acc_q      <= '0;
         y_data_q   <= '0;
         y_row_q    <= '0;
         y_valid_q  <= 1'b0;
         err_q      <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= reject_start;
         if (accept_start) begin
            mode_q  <= mode;
            vbase_q <= v_values_base;
            wbase_q <= wdata_col_base;
            csize_q <= csize;
            rnnz_q  <= row_nnz;
            k_q     <= '0;
            pos_q   <= '0;
            row_q   <= '0;
            err_q   <= 1'b0;
         end
         if (reject_start) err_q <= 1'b1;
         // Stage 0: fetch packed entry
         if (issue) begin
            k_q   <= k_q + ADDR_W'(1);
            pos_q <= pos_last ? '0 : pos_q + ADDR_W'(1);
         end
         if (!stall) begin
            s1_valid_q <= issue;
            if (issue) begin
               s1_col_q   <= dataIn1[IDX_W-1:0];
               s1_mval_q  <= mode_q ? dataIn1[DATA_W-1:IDX_W] : VAL_W'(1);
               s1_first_q <= (pos_q == '0);
               s1_last_q  <= pos_last;
            end
         end
         // Stage 1: gather and accumulate
         if (!stall && s1_valid_q) begin
            acc_q <= sum;
            if (!in_range) err_q <= 1'b1;
         end
         if (!stall && s1_valid_q && s1_last_q) begin
            y_data_q  <= sum;
            y_row_q   <= row_q;
            y_valid_q <= 1'b1;
            row_q     <= row_q + ADDR_W'(1);
         end else if (y_valid_q && y_ready) begin
            y_valid_q <= 1'b0;
         end
      end
   end

endmodule

// File: doc/hht_spmv_engine.md
Name: hht_spmv_engine

Overview:
- Parametrised successor to the HHT `control` block: a sparse row-gather / multiply-accumulate engine.
- Streams packed nonzero entries (value + column index) from memory port 1 and gathers vector elements from port 2 at `v_values_base+col`.
- Accumulates one dot product per row and emits results over a valid/ready handshake.
- Adds over the previous generation: configurable row length, weighted mode, index-range checking and output back-pressure.

Parameters:
- ADDR_W, 32, width of the address and size ports.
- DATA_W, 32, width of `dataIn1`/`dataIn2`.
- IDX_W, 16, column-index field, `dataIn1[IDX_W-1:0]`; the matrix value is `dataIn1[DATA_W-1:IDX_W]`.
- ACC_W, 64, accumulator/result width; arithmetic wraps modulo 2^ACC_W.
- VEC_LEN, 16, number of valid vector entries.

Ports:
- Clk  in  1  clock.
- Rst  in  1  synchronous active-high reset.
- start  in  1  pulse; begins a job when idle.
- mode  in  1  0 = pattern (matrix value forced to 1), 1 = weighted; sampled at start.
- v_values_base  in  ADDR_W  vector base address; sampled at start.
- wdata_col_base  in  ADDR_W  nonzero-stream base address; sampled at start.
- csize  in  ADDR_W  total nonzeros; sampled at start.
- row_nnz  in  ADDR_W  nonzeros per row; sampled at start.
- addr1  out  ADDR_W  nonzero-stream address.
- rd1  out  1  port-1 read enable.
- dataIn1  in  DATA_W  combinational read data for addr1.
- addr2  out  ADDR_W  vector address.
- rd2  out  1  port-2 read enable.
- dataIn2  in  DATA_W  combinational read data for addr2.
- y_data  out  ACC_W  row result.
- y_row  out  ADDR_W  row number of y_data.
- y_valid  out  1  result valid.
- y_ready  in  1  consumer accepts.
- busy  out  1  job in progress.
- done  out  1  one-cycle pulse at job end.
- err  out  1  sticky; cleared at next accepted start.

Behaviour:
- Reset: all outputs 0, state IDLE, counters and accumulator 0. Reset mid-job aborts immediately; no done pulse.
- States and transitions:
  - IDLE: start=1 with csize!=0, row_nnz!=0 and csize%row_nnz==0 -> latch config, clear err, go RUN.
  - IDLE: start with any illegal config -> err=1, done pulses next cycle, stay IDLE.
  - RUN -> DRAIN when the last element has been issued on port 1.
  - DRAIN -> FIN once the stage-1 element has been accumulated.
  - FIN: waits for the final y handshake, then pulses done for 1 cycle -> IDLE.
  - start is ignored while busy=1.
- Pipeline (advances only when stall=0; stall = y_valid & ~y_ready & stage-1 holds a row-last element):
  - S0: addr1 = wdata_col_base+k, rd1=1. Register col = dataIn1[IDX_W-1:0]; mval = dataIn1 upper field if mode=1, else 1. Set first and last flags. k increments.
  - S1: addr2 = v_values_base+col, rd2=1.
    - Product = mval*dataIn2, zero-extended to ACC_W.
    - acc <= (first ? 0 : acc) + product.
    - If last: y_data <= sum, y_row <= row, y_valid <= 1, row++.
- During a stall, addr1/addr2/rd1/rd2/k hold their values. Re-reading is harmless because the memories are combinational.
- y_valid stays high until a cycle with y_valid & y_ready. If a new row-last completes in that same cycle, y_data is replaced back-to-back and y_valid stays 1.
- Latency: y_valid rises 2 cycles after the row's last addr1 issue.
- Throughput: 1 nonzero per cycle when not stalled.
- Index check: col >= VEC_LEN -> err=1 (sticky), rd2=0, product treated as 0, job continues.
- row_nnz=1: every element is both first and last.
- Only IDX_W index bits are used; upper bits are ignored in pattern mode.
- busy=1 from the cycle after start through the done pulse.

Test Plan:
- Reset/idle: hold Rst for 2 cycles -> all outputs 0. start with csize=0 -> err=1, one done pulse, y_valid never asserted.
- Pattern mode: vector at base 2 = [46,39,37,97,97,53,1,31,60,18,48,69,100,77,11,22]. Stream at 180 has cols 6,14,1,8,4,2,4,2; row_nnz=4, csize=8, y_ready=1 -> y=(111,row0), (268,row1); done 1 cycle after the second result is accepted.
- Weighted mode: same stream with value field 3 -> y=333, 804. Value field 0xFFFF on col 12 (v=100) with row_nnz=1 -> y=6553500.
- Back-pressure: as the pattern-mode case but y_ready=0 for 5 cycles after the first y_valid -> addr1/addr2 frozen, y_data holds 111, no result lost, second result 268 follows after acceptance.
- Range error: col=20 in row 0 -> err=1, that element contributes 0, the other rows are unaffected.
- Illegal config and abort: csize=7 with row_nnz=4 -> err=1, no reads issued. Separately, Rst asserted mid-RUN -> busy=0 next cycle and no done pulse.
